score_display: RTL and testbench

- Consumes the game score (binary 0..9999) and the one-cycle new-score strobe produced by the item/bubble logic.
- Converts the score to 4-digit BCD with a sequential double-dabble engine.
- Drives the board's 4-digit multiplexed seven-segment display, with leading-zero blanking.
- Sits beside the VGA path and is clocked by the same system clock.

---
 rtl/score_display_pkg.sv | 36 +++
 rtl/score_display_if.sv | 26 ++
 rtl/score_display_seg7_decoder.sv | 14 +
 rtl/score_display.sv | 144 ++++++++++++++
 tb/tb_score_display.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - shared types, constants and helpers for the score display
package score_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int MAX_SCORE_DEFAULT = 9999;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; entry 0 is the glyph for digit 0.
    localparam logic [0:9][7:0] SEG_CODES = {
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    function automatic logic [7:0] seg7_code(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_CODES[d] : SEG_BLANK;
    endfunction

    // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// rtl/score_display_if.sv - score capture / BCD result interface
interface score_display_if #(
    parameter int SCORE_W = 14
);
    logic [SCORE_W-1:0] score;
    logic               new_score;
    logic               busy;
    logic [15:0]        bcd;
    logic               bcd_valid;

    modport master (
        output score,
        output new_score,
        input  busy,
        input  bcd,
        input  bcd_valid
    );

    modport slave (
        input  score,
        input  new_score,
        output busy,
        output bcd,
        output bcd_valid
    );
endinterface

// File: rtl/score_display_seg7_decoder.sv
// rtl/score_display_seg7_decoder.sv - BCD digit to active-low seven-segment code
module seg7_decoder
    import score_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : seg7_code(digit);
    end

endmodule

// File: rtl/score_display.sv
// rtl/score_display.sv - binary score to BCD with multiplexed 4-digit seven-segment scan
module score_display
    import score_display_pkg::*;
#(
    parameter int SCORE_W      = 14,
    parameter int MAX_SCORE    = MAX_SCORE_DEFAULT,
    parameter int REFRESH_BITS = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    score_display_if.slave       sif,
    output logic [3:0]           an,
    output logic [7:0]           seg
);

    localparam int ITER_W = $clog2(SCORE_W);
    localparam logic [ITER_W-1:0]  LAST_ITER = ITER_W'(SCORE_W - 1);
    localparam logic [SCORE_W-1:0] MAX_CLAMP = SCORE_W'(MAX_SCORE);

    state_t               state, state_nx;
    logic [SCORE_W-1:0]   shift_bin, shift_bin_nx;
    logic [15:0]          shift_bcd, shift_bcd_nx;
    logic [ITER_W-1:0]    iter, iter_nx;
    logic                 pending, pending_nx;
    logic [15:0]          bcd_q, bcd_nx;
    logic                 valid_q, valid_nx;

    logic [SCORE_W-1:0]   clamped;
    logic [15:0]          step_bcd;
    logic [SCORE_W-1:0]   step_bin;

    assign clamped = (sif.score > MAX_CLAMP) ? MAX_CLAMP : sif.score;

    always_comb begin
        {step_bcd, step_bin} = {bcd_adjust(shift_bcd), shift_bin} << 1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            shift_bin <= '0;
            shift_bcd <= '0;
            iter      <= '0;
            pending   <= 1'b0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            shift_bin <= shift_bin_nx;
            shift_bcd <= shift_bcd_nx;
            iter      <= iter_nx;
            pending   <= pending_nx;
            bcd_q     <= bcd_nx;
            valid_q   <= valid_nx;
        end
    end

    // A strobe landing in DONE itself is folded into the recapture decision.
    always_comb begin
        state_nx     = state;
        shift_bin_nx = shift_bin;
        shift_bcd_nx = shift_bcd;
        iter_nx      = iter;
        pending_nx   = pending;
        bcd_nx       = bcd_q;
        valid_nx     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sif.new_score) begin
                    shift_bin_nx = clamped;
                    shift_bcd_nx = '0;
                    iter_nx      = '0;
                    state_nx     = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                shift_bin_nx = step_bin;
                shift_bcd_nx = step_bcd;
                iter_nx      = iter + 1'b1;
                if (sif.new_score) begin
                    pending_nx = 1'b1;
                end
                if (iter == LAST_ITER) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_nx   = shift_bcd;
                valid_nx = 1'b1;
                if (pending || sif.new_score) begin
                    pending_nx   = 1'b0;
                    shift_bin_nx = clamped;
                    shift_bcd_nx = '0;
                    iter_nx      = '0;
                    state_nx     = ST_CONVERT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign sif.busy      = (state != ST_IDLE);
    assign sif.bcd       = bcd_q;
    assign sif.bcd_valid = valid_q;

    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [1:0]              sel;
    logic [3:0]              blank_vec;
    logic [3:0]              digit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign sel = refresh_cnt[REFRESH_BITS-1 -: 2];

    // A digit blanks only when it and every more significant digit are zero.
    always_comb begin
        blank_vec[3] = (bcd_q[15:12] == 4'd0);
        blank_vec[2] = blank_vec[3] && (bcd_q[11:8] == 4'd0);
        blank_vec[1] = blank_vec[2] && (bcd_q[7:4] == 4'd0);
        blank_vec[0] = 1'b0;
    end

    always_comb begin
        digit = bcd_q[{sel, 2'b00} +: 4];
        an    = ~(4'b0001 << sel);
    end

    seg7_decoder u_seg7 (
        .digit (digit),
        .blank (blank_vec[sel]),
        .seg   (seg)
    );

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - scoreboard bench for score_display
module tb_score_display;

    localparam int RB = 6;
    localparam int SCAN_CYCLES = 4 * (2 ** (RB - 2)) + 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] an;
    logic [7:0] seg;

    score_display_if #(.SCORE_W(14)) sif ();

    score_display #(
        .SCORE_W      (14),
        .MAX_SCORE    (9999),
        .REFRESH_BITS (RB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif.slave),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] bcd;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_bcd = 16'h0000;
    logic [7:0]  cap_seg[4];
    bit          cap_seen[4];
    bit          onehot_bad;

    function automatic logic [7:0] code_of(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int clampv(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        int c;
        c = clampv(v);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int pos);
        int c;
        int p10;
        c   = clampv(v);
        p10 = (pos == 0) ? 1 : (pos == 1) ? 10 : (pos == 2) ? 100 : 1000;
        if (pos > 0 && c < p10) return 8'hFF;
        return code_of((c / p10) % 10);
    endfunction

    task automatic drive_strobe(input int v, output int t);
        @(posedge clk);
        #1;
        sif.score     = 14'(v);
        sif.new_score = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        sif.new_score = 1'b0;
    endtask

    task automatic wait_result(input int budget);
        exp_t e;
        bit   got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (sif.bcd_valid) begin
                got = 1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: bcd_valid with bcd=%h, nothing expected", sif.bcd);
                end else begin
                    e = sb.pop_front();
                    if (sif.bcd !== e.bcd || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL sb_result: got bcd=%h at cycle %0d, want %h at cycle %0d",
                                 sif.bcd, cyc, e.bcd, e.cyc);
                    end
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL sb_timeout: no bcd_valid within %0d cycles", budget);
        end
    endtask

    task automatic capture_scan();
        onehot_bad = 0;
        for (int d = 0; d < 4; d++) cap_seen[d] = 0;
        repeat (SCAN_CYCLES) begin
            @(negedge clk);
            case (an)
                4'b1110: begin cap_seg[0] = seg; cap_seen[0] = 1; end
                4'b1101: begin cap_seg[1] = seg; cap_seen[1] = 1; end
                4'b1011: begin cap_seg[2] = seg; cap_seen[2] = 1; end
                4'b0111: begin cap_seg[3] = seg; cap_seen[3] = 1; end
                default: onehot_bad = 1;
            endcase
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        sif.score     = '0;
        sif.new_score = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== 8'hC0) begin
            errors++;
            $display("FAIL reset_display: got an=%b seg=%h, want an=1110 seg=c0", an, seg);
        end
        checks++;
        if (sif.busy !== 1'b0 || sif.bcd !== 16'h0000 || sif.bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b bcd=%h valid=%b, want 0 0000 0",
                     sif.busy, sif.bcd, sif.bcd_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        capture_scan();
        checks++;
        if (onehot_bad) begin
            errors++;
            $display("FAIL reset_onehot: an was not one-hot low during scan");
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (!cap_seen[d] || cap_seg[d] !== exp_seg(0, d)) begin
                errors++;
                $display("FAIL reset_scan digit %0d: got seen=%0d seg=%h, want %h",
                         d, cap_seen[d], cap_seg[d], exp_seg(0, d));
            end
        end
    endtask

    task automatic test_convert(input int v);
        int   t;
        exp_t e;
        drive_strobe(v, t);
        e.bcd = to_bcd(v);
        e.cyc = t + 15;
        sb.push_back(e);
        @(negedge clk);
        checks++;
        if (sif.busy !== 1'b1) begin
            errors++;
            $display("FAIL conv_busy value %0d: got busy=%b, want 1", v, sif.busy);
        end
        while (cyc < t + 7) @(negedge clk);
        checks++;
        if (sif.bcd !== last_bcd) begin
            errors++;
            $display("FAIL conv_hold value %0d: got bcd=%h mid-conversion, want %h", v, sif.bcd, last_bcd);
        end
        wait_result(30);
        checks++;
        if (sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL conv_idle value %0d: got busy=%b after DONE, want 0", v, sif.busy);
        end
        @(negedge clk);
        checks++;
        if (sif.bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL conv_pulse value %0d: got bcd_valid=%b one cycle later, want 0", v, sif.bcd_valid);
        end
        last_bcd = to_bcd(v);
        capture_scan();
        checks++;
        if (onehot_bad) begin
            errors++;
            $display("FAIL conv_onehot value %0d: an was not one-hot low", v);
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (!cap_seen[d] || cap_seg[d] !== exp_seg(v, d)) begin
                errors++;
                $display("FAIL conv_scan value %0d digit %0d: got seen=%0d seg=%h, want %h",
                         v, d, cap_seen[d], cap_seg[d], exp_seg(v, d));
            end
        end
    endtask

    task automatic test_back_to_back();
        int   t;
        int   pulses;
        exp_t e;
        pulses = 0;
        drive_strobe(40, t);
        e.bcd = to_bcd(40);
        e.cyc = t + 15;
        sb.push_back(e);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin sif.score = 14'd50; sif.new_score = 1'b1; end
            if (k == 3) sif.new_score = 1'b0;
            if (k == 7) begin
                sif.score     = 14'd60;
                sif.new_score = 1'b1;
                e.bcd = to_bcd(60);
                e.cyc = t + 30;
                sb.push_back(e);
            end
            if (k == 8) sif.new_score = 1'b0;
            @(negedge clk);
            if (k == 20) begin
                checks++;
                if (sif.bcd !== 16'h0040) begin
                    errors++;
                    $display("FAIL b2b_hold: got bcd=%h during recapture, want 0040", sif.bcd);
                end
            end
            if (sif.bcd_valid) begin
                pulses++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: extra bcd_valid with bcd=%h", sif.bcd);
                end else begin
                    e = sb.pop_front();
                    if (sif.bcd !== e.bcd || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL b2b_result: got bcd=%h at cycle %0d, want %h at cycle %0d",
                                 sif.bcd, cyc, e.bcd, e.cyc);
                    end
                end
            end
        end
        checks++;
        if (pulses != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses and %0d left queued, want 2 and 0", pulses, sb.size());
        end
        last_bcd = to_bcd(60);
    endtask

    task automatic test_reset_abort();
        int t;
        int pulses;
        pulses = 0;
        drive_strobe(9999, t);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 7) begin
                reset = 1'b0;
                #1;
                checks++;
                if (sif.bcd !== 16'h0000 || sif.busy !== 1'b0 || sif.bcd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_reset: got bcd=%h busy=%b valid=%b, want 0000 0 0",
                             sif.bcd, sif.busy, sif.bcd_valid);
                end
            end
            if (k == 9) reset = 1'b1;
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (sif.bcd !== last_bcd) begin
                    errors++;
                    $display("FAIL abort_hold: got bcd=%h before reset, want %h", sif.bcd, last_bcd);
                end
            end
            if (sif.bcd_valid) pulses++;
        end
        checks++;
        if (pulses != 0 || sif.busy !== 1'b0 || sif.bcd !== 16'h0000) begin
            errors++;
            $display("FAIL abort_quiet: got %0d pulses busy=%b bcd=%h, want 0 0 0000",
                     pulses, sif.busy, sif.bcd);
        end
        last_bcd = 16'h0000;
        test_convert(4321);
    endtask

    initial begin
        test_reset();
        test_convert(1234);
        test_convert(10);
        test_convert(12000);
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
